// File: rtl/axi_full_mst_burst.sv
// Single-outstanding AXI4 INCR burst initiator: one read (AR/R) or write (AW/W/B) burst per command.
// Optional macro AXI_MST_4K_CHK_EN rejects commands whose burst would cross a 4 KB boundary.
module axi_full_mst_burst #(
    parameter int DW  = 128,
    parameter int AW  = 32,
    parameter int IDW = 4,
    parameter int ID  = 0
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WR,
    input  logic [AW-1:0]     CMD_ADDR,
    input  logic [7:0]        CMD_LEN,
    input  logic              WD_VALID,
    output logic              WD_READY,
    input  logic [DW-1:0]     WD_DATA,
    input  logic [DW/8-1:0]   WD_STRB,
    output logic              RD_VALID,
    input  logic              RD_READY,
    output logic [DW-1:0]     RD_DATA,
    output logic              RD_LAST,
    output logic              DONE,
    output logic              DONE_ERR,
    output logic [IDW-1:0]    MEM_AWID,
    output logic [AW-1:0]     MEM_AWADDR,
    output logic [7:0]        MEM_AWLEN,
    output logic [2:0]        MEM_AWSIZE,
    output logic [1:0]        MEM_AWBURST,
    output logic              MEM_AWVALID,
    input  logic              MEM_AWREADY,
    output logic [DW-1:0]     MEM_WDATA,
    output logic [DW/8-1:0]   MEM_WSTRB,
    output logic              MEM_WLAST,
    output logic              MEM_WVALID,
    input  logic              MEM_WREADY,
    input  logic [IDW-1:0]    MEM_BID,
    input  logic [1:0]        MEM_BRESP,
    input  logic              MEM_BVALID,
    output logic              MEM_BREADY,
    output logic [IDW-1:0]    MEM_ARID,
    output logic [AW-1:0]     MEM_ARADDR,
    output logic [7:0]        MEM_ARLEN,
    output logic [2:0]        MEM_ARSIZE,
    output logic [1:0]        MEM_ARBURST,
    output logic              MEM_ARVALID,
    input  logic              MEM_ARREADY,
    input  logic [IDW-1:0]    MEM_RID,
    input  logic [DW-1:0]     MEM_RDATA,
    input  logic [1:0]        MEM_RRESP,
    input  logic              MEM_RLAST,
    input  logic              MEM_RVALID,
    output logic              MEM_RREADY,
    output logic [2:0]        state_dbg
);
    // Handshakes: a transfer happens on a rising edge where VALID && READY; VALID never
    // depends on READY, and a raised VALID holds with stable payload until that edge.

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_FIN} state_t;

    localparam logic [2:0] AXSIZE = 3'($clog2(DW/8));

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [7:0]    len_q;
    logic [7:0]    beat_q;
    logic          err_q;
    logic          last_beat;
    logic          unused_ids;

    assign last_beat  = (beat_q == len_q);
    assign unused_ids = ^{MEM_BID, MEM_RID};
    assign state_dbg  = state_q;

`ifdef AXI_MST_4K_CHK_EN
    logic [31:0] burst_end;
    logic        cross_4k;
    assign burst_end = 32'(CMD_ADDR[11:0]) + (32'(CMD_LEN) + 32'd1) * 32'(DW/8);
    assign cross_4k  = (burst_end > 32'd4096);
`endif

    assign MEM_AWID    = IDW'(ID);
    assign MEM_AWADDR  = addr_q;
    assign MEM_AWLEN   = len_q;
    assign MEM_AWSIZE  = AXSIZE;
    assign MEM_AWBURST = 2'b01;
    assign MEM_ARID    = IDW'(ID);
    assign MEM_ARADDR  = addr_q;
    assign MEM_ARLEN   = len_q;
    assign MEM_ARSIZE  = AXSIZE;
    assign MEM_ARBURST = 2'b01;
    assign MEM_WDATA   = WD_DATA;
    assign MEM_WSTRB   = WD_STRB;
    assign RD_DATA     = MEM_RDATA;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (CMD_VALID) begin
                    addr_q <= CMD_ADDR;
                    len_q  <= CMD_LEN;
                    beat_q <= '0;
`ifdef AXI_MST_4K_CHK_EN
                    err_q  <= cross_4k;
`endif
                end
                // Sticky error on bad RRESP or on RLAST disagreeing with the beat count.
                S_R: if (MEM_RVALID && RD_READY) begin
                    beat_q <= beat_q + 8'd1;
                    if ((MEM_RRESP != 2'b00) || (MEM_RLAST != last_beat))
                        err_q <= 1'b1;
                end
                S_W: if (WD_VALID && MEM_WREADY) beat_q <= beat_q + 8'd1;
                S_B: if (MEM_BVALID && (MEM_BRESP != 2'b00)) err_q <= 1'b1;
                S_FIN: err_q <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        CMD_READY   = 1'b0;
        MEM_ARVALID = 1'b0;
        MEM_AWVALID = 1'b0;
        MEM_RREADY  = 1'b0;
        RD_VALID    = 1'b0;
        RD_LAST     = 1'b0;
        MEM_WVALID  = 1'b0;
        WD_READY    = 1'b0;
        MEM_WLAST   = 1'b0;
        MEM_BREADY  = 1'b0;
        DONE        = 1'b0;
        DONE_ERR    = 1'b0;
        case (state_q)
            S_IDLE: begin
                CMD_READY = 1'b1;
                if (CMD_VALID) begin
                    state_d = CMD_WR ? S_AW : S_AR;
`ifdef AXI_MST_4K_CHK_EN
                    if (cross_4k) state_d = S_FIN;
`endif
                end
            end
            S_AR: begin
                MEM_ARVALID = 1'b1;
                if (MEM_ARREADY) state_d = S_R;
            end
            S_R: begin
                MEM_RREADY = RD_READY;
                RD_VALID   = MEM_RVALID;
                RD_LAST    = MEM_RLAST;
                if (MEM_RVALID && RD_READY && MEM_RLAST) state_d = S_FIN;
            end
            S_AW: begin
                MEM_AWVALID = 1'b1;
                if (MEM_AWREADY) state_d = S_W;
            end
            S_W: begin
                MEM_WVALID = WD_VALID;
                WD_READY   = MEM_WREADY;
                MEM_WLAST  = last_beat;
                if (WD_VALID && MEM_WREADY && last_beat) state_d = S_B;
            end
            S_B: begin
                MEM_BREADY = 1'b1;
                if (MEM_BVALID) state_d = S_FIN;
            end
            S_FIN: begin
                DONE     = 1'b1;
                DONE_ERR = err_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_full_mst_burst.sv
// Directed bench for axi_full_mst_burst: the bench plays both the command source and the AXI slave.
module tb_axi_full_mst_burst;

  localparam int DW  = 128;
  localparam int AW  = 32;
  localparam int IDW = 4;

  logic            CLK, RSTn;
  logic            CMD_VALID, CMD_READY, CMD_WR;
  logic [AW-1:0]   CMD_ADDR;
  logic [7:0]      CMD_LEN;
  logic            WD_VALID, WD_READY;
  logic [DW-1:0]   WD_DATA;
  logic [DW/8-1:0] WD_STRB;
  logic            RD_VALID, RD_READY, RD_LAST;
  logic [DW-1:0]   RD_DATA;
  logic            DONE, DONE_ERR;
  logic [IDW-1:0]  MEM_AWID, MEM_ARID, MEM_BID, MEM_RID;
  logic [AW-1:0]   MEM_AWADDR, MEM_ARADDR;
  logic [7:0]      MEM_AWLEN, MEM_ARLEN;
  logic [2:0]      MEM_AWSIZE, MEM_ARSIZE;
  logic [1:0]      MEM_AWBURST, MEM_ARBURST;
  logic            MEM_AWVALID, MEM_AWREADY, MEM_ARVALID, MEM_ARREADY;
  logic [DW-1:0]   MEM_WDATA, MEM_RDATA;
  logic [DW/8-1:0] MEM_WSTRB;
  logic            MEM_WLAST, MEM_WVALID, MEM_WREADY;
  logic [1:0]      MEM_BRESP, MEM_RRESP;
  logic            MEM_BVALID, MEM_BREADY;
  logic            MEM_RLAST, MEM_RVALID, MEM_RREADY;
  logic [2:0]      state_dbg;

  int n_checks = 0;
  int n_passed = 0;
  int n_failed = 0;

  logic [DW-1:0] mem [logic [31:0]];
  logic [DW-1:0] exp_q[$];

  axi_full_mst_burst #(.DW(DW), .AW(AW), .IDW(IDW), .ID(0)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WR(CMD_WR),
    .CMD_ADDR(CMD_ADDR), .CMD_LEN(CMD_LEN),
    .WD_VALID(WD_VALID), .WD_READY(WD_READY), .WD_DATA(WD_DATA), .WD_STRB(WD_STRB),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY), .RD_DATA(RD_DATA), .RD_LAST(RD_LAST),
    .DONE(DONE), .DONE_ERR(DONE_ERR),
    .MEM_AWID(MEM_AWID), .MEM_AWADDR(MEM_AWADDR), .MEM_AWLEN(MEM_AWLEN),
    .MEM_AWSIZE(MEM_AWSIZE), .MEM_AWBURST(MEM_AWBURST), .MEM_AWVALID(MEM_AWVALID),
    .MEM_AWREADY(MEM_AWREADY),
    .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB), .MEM_WLAST(MEM_WLAST),
    .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY),
    .MEM_BID(MEM_BID), .MEM_BRESP(MEM_BRESP), .MEM_BVALID(MEM_BVALID), .MEM_BREADY(MEM_BREADY),
    .MEM_ARID(MEM_ARID), .MEM_ARADDR(MEM_ARADDR), .MEM_ARLEN(MEM_ARLEN),
    .MEM_ARSIZE(MEM_ARSIZE), .MEM_ARBURST(MEM_ARBURST), .MEM_ARVALID(MEM_ARVALID),
    .MEM_ARREADY(MEM_ARREADY),
    .MEM_RID(MEM_RID), .MEM_RDATA(MEM_RDATA), .MEM_RRESP(MEM_RRESP), .MEM_RLAST(MEM_RLAST),
    .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_passed++;
    else begin
      n_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int v);
    logic [7:0] b;
    b = 8'(v);
    return {16{b}};
  endfunction

  // ---------------- drivers ----------------
  task automatic send_cmd(input logic wr, input logic [31:0] addr, input int len);
    CMD_VALID = 1'b1;
    CMD_WR    = wr;
    CMD_ADDR  = addr;
    CMD_LEN   = 8'(len);
    #1 check("cmd_ready_idle", CMD_READY, 1'b1);
    @(negedge CLK);
    CMD_VALID = 1'b0;
  endtask

  task automatic finish_check(input logic exp_err);
    #1 check("done_pulse", DONE, 1'b1);
    check("done_err", DONE_ERR, exp_err);
    @(negedge CLK);
    #1 check("done_one_cycle", DONE, 1'b0);
    check("cmd_ready_after_done", CMD_READY, 1'b1);
  endtask

  task automatic wr_burst(input logic [31:0] addr, input int len, input int seed,
                          input logic [1:0] bresp, input logic exp_err, input int abort_at);
    send_cmd(1'b1, addr, len);
    WD_VALID = 1'b1;
    WD_DATA  = pat(seed);
    WD_STRB  = '1;
    #1 check("awvalid", MEM_AWVALID, 1'b1);
    check("awaddr", MEM_AWADDR, addr);
    check("awlen", MEM_AWLEN, 8'(len));
    check("awsize", MEM_AWSIZE, 3'd4);
    check("awburst", MEM_AWBURST, 2'b01);
    check("awid", MEM_AWID, 4'd0);
    check("no_w_before_aw", MEM_WVALID, 1'b0);
    MEM_AWREADY = 1'b1;
    @(negedge CLK);
    MEM_AWREADY = 1'b0;
    for (int i = 0; i <= len; i++) begin
      WD_DATA    = pat(seed + i);
      MEM_WREADY = 1'b1;
      #1 check("wvalid", MEM_WVALID, 1'b1);
      check("awvalid_dropped", MEM_AWVALID, 1'b0);
      check("wdata", MEM_WDATA, pat(seed + i));
      check("wlast", MEM_WLAST, (i == len));
      check("wd_ready", WD_READY, 1'b1);
      if (i == abort_at) begin
        RSTn = 1'b0;
        #1 check("rst_wvalid", MEM_WVALID, 1'b0);
        check("rst_wlast", MEM_WLAST, 1'b0);
        check("rst_wd_ready", WD_READY, 1'b0);
        check("rst_awaddr", MEM_AWADDR, 32'd0);
        check("rst_awlen", MEM_AWLEN, 8'd0);
        check("rst_cmd_ready", CMD_READY, 1'b1);
        check("rst_done", DONE, 1'b0);
        return;
      end
      mem[addr + 32'(16 * i)] = pat(seed + i);
      @(negedge CLK);
    end
    WD_VALID   = 1'b0;
    MEM_WREADY = 1'b0;
    #1 check("bready", MEM_BREADY, 1'b1);
    check("wvalid_after_last", MEM_WVALID, 1'b0);
    check("no_done_before_b", DONE, 1'b0);
    MEM_BVALID = 1'b1;
    MEM_BRESP  = bresp;
    @(negedge CLK);
    MEM_BVALID = 1'b0;
    MEM_BRESP  = 2'b00;
    finish_check(exp_err);
  endtask

  task automatic rd_burst(input logic [31:0] addr, input int len, input int ar_delay,
                          input bit toggle, input int rlast_at, input logic [1:0] rresp,
                          input logic exp_err);
    int  beat;
    int  cyc;
    bit  done_r;
    send_cmd(1'b0, addr, len);
    #1 check("arvalid", MEM_ARVALID, 1'b1);
    check("araddr", MEM_ARADDR, addr);
    check("arlen", MEM_ARLEN, 8'(len));
    check("arsize", MEM_ARSIZE, 3'd4);
    check("arburst", MEM_ARBURST, 2'b01);
    check("awvalid_on_read", MEM_AWVALID, 1'b0);
    repeat (ar_delay) begin
      @(negedge CLK);
      #1 check("arvalid_hold", MEM_ARVALID, 1'b1);
      check("araddr_hold", MEM_ARADDR, addr);
    end
    MEM_ARREADY = 1'b1;
    @(negedge CLK);
    MEM_ARREADY = 1'b0;
    for (int b = 0; b <= rlast_at && b <= len; b++) exp_q.push_back(mem[addr + 32'(16 * b)]);
    beat   = 0;
    cyc    = 0;
    done_r = 1'b0;
    while (!done_r && cyc < 64) begin
      MEM_RVALID = 1'b1;
      MEM_RDATA  = mem[addr + 32'(16 * beat)];
      MEM_RLAST  = (beat == rlast_at);
      MEM_RRESP  = rresp;
      RD_READY   = toggle ? cyc[0] : 1'b1;
      #1 check("rd_valid", RD_VALID, 1'b1);
      check("rd_last", RD_LAST, (beat == rlast_at));
      check("rready_follow", MEM_RREADY, RD_READY);
      check("arvalid_dropped", MEM_ARVALID, 1'b0);
      if (RD_READY) begin
        check("rd_data", RD_DATA, exp_q.pop_front());
        if (beat == rlast_at) done_r = 1'b1;
        beat++;
      end
      cyc++;
      @(negedge CLK);
    end
    check("read_finished", done_r, 1'b1);
    MEM_RVALID = 1'b0;
    MEM_RLAST  = 1'b0;
    MEM_RRESP  = 2'b00;
    RD_READY   = 1'b0;
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    finish_check(exp_err);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    RSTn = 1'b0;
    CMD_VALID = 1'b0; CMD_WR = 1'b0; CMD_ADDR = '0; CMD_LEN = '0;
    WD_VALID = 1'b0; WD_DATA = '0; WD_STRB = '0; RD_READY = 1'b0;
    MEM_AWREADY = 1'b0; MEM_WREADY = 1'b0; MEM_ARREADY = 1'b0;
    MEM_BID = '0; MEM_BRESP = '0; MEM_BVALID = 1'b0;
    MEM_RID = '0; MEM_RDATA = '0; MEM_RRESP = '0; MEM_RLAST = 1'b0; MEM_RVALID = 1'b0;

    repeat (3) @(negedge CLK);
    #1 check("reset_cmd_ready", CMD_READY, 1'b1);
    check("reset_awvalid", MEM_AWVALID, 1'b0);
    check("reset_arvalid", MEM_ARVALID, 1'b0);
    check("reset_wvalid", MEM_WVALID, 1'b0);
    check("reset_rd_valid", RD_VALID, 1'b0);
    check("reset_done", DONE, 1'b0);
    check("reset_done_err", DONE_ERR, 1'b0);
    check("reset_wlast", MEM_WLAST, 1'b0);
    check("reset_rd_last", RD_LAST, 1'b0);
    check("reset_araddr", MEM_ARADDR, 32'd0);
    check("reset_arlen", MEM_ARLEN, 8'd0);
    check("reset_bready", MEM_BREADY, 1'b0);
    RSTn = 1'b1;
    @(negedge CLK);

    // 4-beat write then read back with a throttled sink
    wr_burst(32'h8000_0000, 3, 1, 2'b00, 1'b0, -1);
    rd_burst(32'h8000_0000, 3, 0, 1'b1, 3, 2'b00, 1'b0);

    // single beat read with AR stalled 10 cycles
    rd_burst(32'h8000_0000, 0, 10, 1'b0, 0, 2'b00, 1'b0);

    // SLVERR on B, then a clean read clears the error
    wr_burst(32'h8000_1000, 1, 8'h21, 2'b10, 1'b1, -1);
    rd_burst(32'h8000_1000, 1, 2, 1'b0, 1, 2'b00, 1'b0);

    // error read response, then RLAST arriving early
    rd_burst(32'h8000_0000, 3, 0, 1'b0, 3, 2'b10, 1'b1);
    rd_burst(32'h8000_0000, 3, 0, 1'b0, 1, 2'b00, 1'b1);

    // reset asserted during W beat 2 of an 8-beat write
    wr_burst(32'h8000_2000, 7, 8'h31, 2'b00, 1'b0, 2);
    WD_VALID = 1'b0;
    MEM_WREADY = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      #1 check("post_rst_no_done", DONE, 1'b0);
      check("post_rst_cmd_ready", CMD_READY, 1'b1);
      check("post_rst_no_wvalid", MEM_WVALID, 1'b0);
    end

    // burst crossing a 4 KB boundary
`ifdef AXI_MST_4K_CHK_EN
    send_cmd(1'b1, 32'h8000_0FF0, 1);
    #1 check("4k_no_awvalid", MEM_AWVALID, 1'b0);
    finish_check(1'b1);
`else
    wr_burst(32'h8000_0FF0, 1, 8'h41, 2'b00, 1'b0, -1);
`endif

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
